// File: rtl/mrd_pkg.sv
// Shared types and constants for the mixed-radix DFT frame sequencer.
package mrd_pkg;

  // Frame phases in the order the memory top walks through them.
  typedef enum logic [1:0] {
    ST_SINK   = 2'b00,
    ST_RD     = 2'b01,
    ST_WR     = 2'b10,
    ST_SOURCE = 2'b11
  } mrd_state_t;

  // Number of entries in the per-stage radix table.
  localparam int STAGES_MAX = 6;
  // Number of prime-factor-algorithm factors.
  localparam int NUM_PFA    = 3;

  // Only size currently supported by the datapath.
  localparam logic [11:0] SIZE_1200 = 12'd1200;

  // Everything the datapath needs to know about one frame size.
  typedef struct packed {
    logic                        supported;
    logic [2:0]                  num_stages;
    logic [STAGES_MAX-1:0][2:0]  nf;
    logic [NUM_PFA-1:0][9:0]     nf_pfa;
    logic [9:0]                  q_p;
    logic [9:0]                  r_p;
    logic [9:0]                  q_p_o;
    logic [9:0]                  r_p_o;
  } mrd_cfg_t;

endpackage

// File: rtl/mrd_cfg_rom.sv
// Combinational size table: DFT size -> stage radices and PFA constants.
module mrd_cfg_rom
  import mrd_pkg::*;
(
  input  logic [11:0] dftpts,
  output mrd_cfg_t    cfg
);

  // Decode the size; anything not listed is reported unsupported with an all-1 radix table.
  // PFA constants for factors N1,N2,N3:
  //   q_p   = (N2*N3)^-1 mod N1,  r_p   = (N1*N3)^-1 mod N2
  //   q_p_o = N2*N3,              r_p_o = N1*N3
  always_comb begin
    cfg    = '0;
    cfg.nf = {STAGES_MAX{3'd1}};
    case (dftpts)
      SIZE_1200: begin
        cfg.supported  = 1'b1;
        cfg.num_stages = 3'd5;
        cfg.nf[0]      = 3'd4;
        cfg.nf[1]      = 3'd4;
        cfg.nf[2]      = 3'd5;
        cfg.nf[3]      = 3'd5;
        cfg.nf[4]      = 3'd3;
        cfg.nf[5]      = 3'd1;
        cfg.nf_pfa[0]  = 10'd16;
        cfg.nf_pfa[1]  = 10'd25;
        cfg.nf_pfa[2]  = 10'd3;
        cfg.q_p        = 10'd3;
        cfg.r_p        = 10'd12;
        cfg.q_p_o      = 10'd75;
        cfg.r_p_o      = 10'd48;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mrd_ctrl_fsm.sv
// Frame-level sequencer: sink -> (read -> write) x stages -> source -> sink,
// with per-phase timeout and unsupported-size / dropped-sop reporting.
module mrd_ctrl_fsm
  import mrd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sink_sop,
  input  logic [11:0]                sink_dftpts,
  input  logic                       sink_ongoing,
  input  logic                       rd_ongoing,
  input  logic                       wr_ongoing,
  input  logic                       source_ongoing,
  output logic [1:0]                 state,
  output logic [2:0]                 current_stage,
  output logic [11:0]                dftpts,
  output logic [STAGES_MAX-1:0][2:0] nf,
  output logic [NUM_PFA-1:0][9:0]    nf_pfa,
  output logic [9:0]                 q_p,
  output logic [9:0]                 r_p,
  output logic [9:0]                 q_p_o,
  output logic [9:0]                 r_p_o,
  output logic                       sink_ready,
  output logic                       frame_done,
  output logic                       err_unsup,
  output logic                       err_timeout,
  output logic                       sop_dropped
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mrd_state_t                 state_reg;
  logic [2:0]                 stage_reg;
  logic [2:0]                 num_stages_reg;
  logic [11:0]                dftpts_reg;
  logic [STAGES_MAX-1:0][2:0] nf_reg;
  logic [NUM_PFA-1:0][9:0]    nf_pfa_reg;
  logic [9:0]                 q_p_reg;
  logic [9:0]                 r_p_reg;
  logic [9:0]                 q_p_o_reg;
  logic [9:0]                 r_p_o_reg;
  logic                       sink_ready_reg;
  logic                       frame_done_reg;
  logic                       err_unsup_reg;
  logic                       err_timeout_reg;
  logic                       sop_dropped_reg;
  logic                       seen_reg;
  logic [CNT_W-1:0]           phase_cnt_reg;
  logic                       sink_q;
  logic                       sink_q2;
  logic                       rd_q;
  logic                       wr_q;
  logic                       src_q;
  logic                       busy_q;
  mrd_cfg_t                   rom_cfg;

  mrd_cfg_rom u_cfg_rom (
    .dftpts (sink_dftpts),
    .cfg    (rom_cfg)
  );

  // Pick the registered activity flag that belongs to the current phase.
  always_comb begin
    busy_q = 1'b0;
    case (state_reg)
      ST_RD:     busy_q = rd_q;
      ST_WR:     busy_q = wr_q;
      ST_SOURCE: busy_q = src_q;
      default:   busy_q = 1'b0;
    endcase
  end

  // Phase sequencing, config latch, timeout and error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_SINK;
      stage_reg       <= '0;
      num_stages_reg  <= '0;
      dftpts_reg      <= '0;
      nf_reg          <= {STAGES_MAX{3'd1}};
      nf_pfa_reg      <= '0;
      q_p_reg         <= '0;
      r_p_reg         <= '0;
      q_p_o_reg       <= '0;
      r_p_o_reg       <= '0;
      sink_ready_reg  <= 1'b1;
      frame_done_reg  <= 1'b0;
      err_unsup_reg   <= 1'b0;
      err_timeout_reg <= 1'b0;
      sop_dropped_reg <= 1'b0;
      seen_reg        <= 1'b0;
      phase_cnt_reg   <= '0;
      sink_q          <= 1'b0;
      sink_q2         <= 1'b0;
      rd_q            <= 1'b0;
      wr_q            <= 1'b0;
      src_q           <= 1'b0;
    end else begin
      sink_q          <= sink_ongoing;
      sink_q2         <= sink_q;
      rd_q            <= rd_ongoing;
      wr_q            <= wr_ongoing;
      src_q           <= source_ongoing;
      frame_done_reg  <= 1'b0;
      err_unsup_reg   <= 1'b0;
      err_timeout_reg <= 1'b0;
      sop_dropped_reg <= 1'b0;

      case (state_reg)
        ST_SINK: begin
          // Sink phase ends on the falling edge of sink_ongoing once a frame is latched.
          if (!sink_ready_reg && sink_q2 && !sink_q) begin
            state_reg     <= ST_RD;
            stage_reg     <= '0;
            seen_reg      <= 1'b0;
            phase_cnt_reg <= '0;
          end
        end
        default: begin
          if (phase_cnt_reg == CNT_LAST) begin
            // Hung phase: abandon the frame and reopen the sink.
            state_reg       <= ST_SINK;
            stage_reg       <= '0;
            sink_ready_reg  <= 1'b1;
            err_timeout_reg <= 1'b1;
            seen_reg        <= 1'b0;
            phase_cnt_reg   <= '0;
          end else if (seen_reg && !busy_q) begin
            seen_reg      <= 1'b0;
            phase_cnt_reg <= '0;
            case (state_reg)
              ST_RD: state_reg <= ST_WR;
              ST_WR: begin
                if (stage_reg == num_stages_reg - 3'd1) begin
                  state_reg <= ST_SOURCE;
                end else begin
                  stage_reg <= stage_reg + 3'd1;
                  state_reg <= ST_RD;
                end
              end
              default: begin
                state_reg      <= ST_SINK;
                stage_reg      <= '0;
                sink_ready_reg <= 1'b1;
                frame_done_reg <= 1'b1;
              end
            endcase
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 1'b1;
            if (busy_q) begin
              seen_reg <= 1'b1;
            end
          end
        end
      endcase

      // Start-of-frame: accept only in an idle sink, otherwise report it.
      if (sink_sop) begin
        if (state_reg == ST_SINK && sink_ready_reg) begin
          if (rom_cfg.supported) begin
            dftpts_reg     <= sink_dftpts;
            num_stages_reg <= rom_cfg.num_stages;
            nf_reg         <= rom_cfg.nf;
            nf_pfa_reg     <= rom_cfg.nf_pfa;
            q_p_reg        <= rom_cfg.q_p;
            r_p_reg        <= rom_cfg.r_p;
            q_p_o_reg      <= rom_cfg.q_p_o;
            r_p_o_reg      <= rom_cfg.r_p_o;
            sink_ready_reg <= 1'b0;
          end else begin
            err_unsup_reg <= 1'b1;
          end
        end else begin
          sop_dropped_reg <= 1'b1;
        end
      end
    end
  end

  assign state         = state_reg;
  assign current_stage = stage_reg;
  assign dftpts        = dftpts_reg;
  assign nf            = nf_reg;
  assign nf_pfa        = nf_pfa_reg;
  assign q_p           = q_p_reg;
  assign r_p           = r_p_reg;
  assign q_p_o         = q_p_o_reg;
  assign r_p_o         = r_p_o_reg;
  assign sink_ready    = sink_ready_reg;
  assign frame_done    = frame_done_reg;
  assign err_unsup     = err_unsup_reg;
  assign err_timeout   = err_timeout_reg;
  assign sop_dropped   = sop_dropped_reg;

endmodule

// File: tb/tb_mrd_ctrl_fsm.sv
// Bench for mrd_ctrl_fsm: event-level reference model plus directed scenarios.
module tb_mrd_ctrl_fsm;

  localparam int TIMEOUT = 4096;

  logic             clk;
  logic             rst_n;
  logic             sink_sop;
  logic [11:0]      sink_dftpts;
  logic             sink_ongoing;
  logic             rd_ongoing;
  logic             wr_ongoing;
  logic             source_ongoing;
  logic [1:0]       state;
  logic [2:0]       current_stage;
  logic [11:0]      dftpts;
  logic [5:0][2:0]  nf;
  logic [2:0][9:0]  nf_pfa;
  logic [9:0]       q_p;
  logic [9:0]       r_p;
  logic [9:0]       q_p_o;
  logic [9:0]       r_p_o;
  logic             sink_ready;
  logic             frame_done;
  logic             err_unsup;
  logic             err_timeout;
  logic             sop_dropped;

  mrd_ctrl_fsm #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sink_sop       (sink_sop),
    .sink_dftpts    (sink_dftpts),
    .sink_ongoing   (sink_ongoing),
    .rd_ongoing     (rd_ongoing),
    .wr_ongoing     (wr_ongoing),
    .source_ongoing (source_ongoing),
    .state          (state),
    .current_stage  (current_stage),
    .dftpts         (dftpts),
    .nf             (nf),
    .nf_pfa         (nf_pfa),
    .q_p            (q_p),
    .r_p            (r_p),
    .q_p_o          (q_p_o),
    .r_p_o          (r_p_o),
    .sink_ready     (sink_ready),
    .frame_done     (frame_done),
    .err_unsup      (err_unsup),
    .err_timeout    (err_timeout),
    .sop_dropped    (sop_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int printed = 0;
  bit chk_en = 0;
  int fd_count = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (printed < 40) begin
        printed++;
        $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
    end
  endfunction

  // ---------------- size table derived from factorisation rules ----------
  bit cfg_sup;
  int cfg_ns;
  int cfg_nf[6];
  int cfg_pfa[3];
  int cfg_qp, cfg_rp, cfg_qpo, cfg_rpo;

  function automatic int inv_mod(input int a, input int m);
    for (int x = 1; x < m; x++) if ((a * x) % m == 1) return x;
    return 0;
  endfunction

  function automatic void load_cfg(input int size);
    cfg_sup = 0; cfg_ns = 0;
    cfg_nf  = '{1, 1, 1, 1, 1, 1};
    cfg_pfa = '{0, 0, 0};
    cfg_qp = 0; cfg_rp = 0; cfg_qpo = 0; cfg_rpo = 0;
    if (size == 1200) begin
      cfg_sup = 1; cfg_ns = 5;
      cfg_nf  = '{4, 4, 5, 5, 3, 1};
      cfg_pfa = '{16, 25, 3};
      cfg_qpo = cfg_pfa[1] * cfg_pfa[2];
      cfg_rpo = cfg_pfa[0] * cfg_pfa[2];
      cfg_qp  = inv_mod(cfg_qpo % cfg_pfa[0], cfg_pfa[0]);
      cfg_rp  = inv_mod(cfg_rpo % cfg_pfa[1], cfg_pfa[1]);
    end
  endfunction

  // ---------------- reference model (event level, timestamp based) -------
  int m_state, m_stage, m_dft, m_ns;
  int m_nf[6];
  int m_pfa[3];
  int m_qp, m_rp, m_qpo, m_rpo;
  bit m_ready, m_fd, m_unsup, m_to, m_drop, m_seen;
  int now_cyc = 0;
  int m_entry;
  bit sink_h1, sink_h2, rd_h1, wr_h1, src_h1;

  function automatic void m_enter(input int st);
    m_state = st;
    m_entry = now_cyc;
    m_seen  = 0;
  endfunction

  always @(posedge clk) begin : model
    int os;
    bit ordy;
    bit act;
    if (!rst_n) begin
      m_state = 0; m_stage = 0; m_dft = 0; m_ns = 0;
      m_nf = '{1, 1, 1, 1, 1, 1};
      m_pfa = '{0, 0, 0};
      m_qp = 0; m_rp = 0; m_qpo = 0; m_rpo = 0;
      m_ready = 1; m_fd = 0; m_unsup = 0; m_to = 0; m_drop = 0; m_seen = 0;
      m_entry = now_cyc;
      sink_h1 = 0; sink_h2 = 0; rd_h1 = 0; wr_h1 = 0; src_h1 = 0;
    end else begin
      os = m_state; ordy = m_ready;
      m_fd = 0; m_unsup = 0; m_to = 0; m_drop = 0;
      if (os == 0) begin
        if (!ordy && sink_h2 && !sink_h1) begin
          m_stage = 0;
          m_enter(1);
        end
      end else begin
        act = (os == 1) ? rd_h1 : (os == 2) ? wr_h1 : src_h1;
        if (now_cyc - m_entry == TIMEOUT) begin
          m_to = 1; m_stage = 0; m_ready = 1;
          m_enter(0);
        end else if (m_seen && !act) begin
          if (os == 1) m_enter(2);
          else if (os == 2) begin
            if (m_stage == m_ns - 1) m_enter(3);
            else begin m_stage++; m_enter(1); end
          end else begin
            m_fd = 1; m_stage = 0; m_ready = 1;
            m_enter(0);
          end
        end else if (act) begin
          m_seen = 1;
        end
      end
      if (sink_sop) begin
        if (os == 0 && ordy) begin
          load_cfg(int'(sink_dftpts));
          if (cfg_sup) begin
            m_dft = int'(sink_dftpts); m_ns = cfg_ns;
            m_nf = cfg_nf; m_pfa = cfg_pfa;
            m_qp = cfg_qp; m_rp = cfg_rp; m_qpo = cfg_qpo; m_rpo = cfg_rpo;
            m_ready = 0;
          end else m_unsup = 1;
        end else m_drop = 1;
      end
      sink_h2 = sink_h1; sink_h1 = sink_ongoing;
      rd_h1 = rd_ongoing; wr_h1 = wr_ongoing; src_h1 = source_ongoing;
    end
    now_cyc++;
  end

  // Compare every output against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(state), m_state);
      chk("stage", int'(current_stage), m_stage);
      chk("dftpts", int'(dftpts), m_dft);
      chk("sink_ready", int'(sink_ready), int'(m_ready));
      chk("frame_done", int'(frame_done), int'(m_fd));
      chk("err_unsup", int'(err_unsup), int'(m_unsup));
      chk("err_timeout", int'(err_timeout), int'(m_to));
      chk("sop_dropped", int'(sop_dropped), int'(m_drop));
      for (int i = 0; i < 6; i++) chk("nf", int'(nf[i]), m_nf[i]);
      for (int i = 0; i < 3; i++) chk("nf_pfa", int'(nf_pfa[i]), m_pfa[i]);
      chk("q_p", int'(q_p), m_qp);
      chk("r_p", int'(r_p), m_rp);
      chk("q_p_o", int'(q_p_o), m_qpo);
      chk("r_p_o", int'(r_p_o), m_rpo);
    end
    if (frame_done === 1'b1) fd_count++;
  end

  // ---------------- stimulus helpers -------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sop(input int size);
    sink_sop = 1'b1;
    sink_dftpts = 12'(size);
    tick();
    sink_sop = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (int'(state) != s && n < budget) begin
      tick();
      n++;
    end
    if (int'(state) != s) chk("wait_state_timeout", int'(state), s);
  endtask

  task automatic busy(input int which, input int len);
    repeat ($urandom_range(0, 3)) tick();
    case (which)
      1: rd_ongoing = 1'b1;
      2: wr_ongoing = 1'b1;
      default: source_ongoing = 1'b1;
    endcase
    repeat (len) tick();
    rd_ongoing = 1'b0; wr_ongoing = 1'b0; source_ongoing = 1'b0;
  endtask

  task automatic sink_phase(input int len);
    sink_ongoing = 1'b1;
    repeat (len) tick();
    sink_ongoing = 1'b0;
  endtask

  task automatic run_after_sink(input int plen, input bit inject);
    for (int s = 0; s < 5; s++) begin
      wait_state(1, 20);
      chk("rd_stage", int'(current_stage), s);
      if (inject && $urandom_range(0, 2) == 0) begin
        send_sop(int'($urandom_range(0, 4095)));
      end
      busy(1, plen);
      wait_state(2, 20);
      busy(2, plen);
    end
    wait_state(3, 20);
    busy(3, plen);
    wait_state(0, 20);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + randomized sequence -----------------------
  initial begin : main
    int fd0, n, plen;
    rst_n = 1'b0; sink_sop = 1'b0; sink_dftpts = '0;
    sink_ongoing = 1'b0; rd_ongoing = 1'b0; wr_ongoing = 1'b0; source_ongoing = 1'b0;

    // pin the model's size table with hand-computed values
    load_cfg(1200);
    chk("pin_prod_nf", cfg_nf[0]*cfg_nf[1]*cfg_nf[2]*cfg_nf[3]*cfg_nf[4]*cfg_nf[5], 1200);
    chk("pin_prod_pfa", cfg_pfa[0]*cfg_pfa[1]*cfg_pfa[2], 1200);
    chk("pin_qp", cfg_qp, 3);
    chk("pin_rp", cfg_rp, 12);
    load_cfg(1000);
    chk("pin_unsup", int'(cfg_sup), 0);

    tick();
    chk_en = 1;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_state", int'(state), 0);
    chk("rst_ready", int'(sink_ready), 1);
    chk("rst_nf5", int'(nf[5]), 1);
    chk("rst_dft", int'(dftpts), 0);

    // frame 1: long sink, 240-cycle phases, sop injected during RD
    send_sop(1200);
    chk("sop_ready", int'(sink_ready), 0);
    sink_phase(1200);
    tick();
    chk("sink_fall_lat1", int'(state), 0);
    tick();
    chk("sink_fall_lat2", int'(state), 1);
    chk("f1_stage", int'(current_stage), 0);
    chk("f1_nf0", int'(nf[0]), 4);
    chk("f1_pfa0", int'(nf_pfa[0]), 16);
    chk("f1_pfa1", int'(nf_pfa[1]), 25);
    chk("f1_pfa2", int'(nf_pfa[2]), 3);
    send_sop(1000);
    chk("drop_pulse", int'(sop_dropped), 1);
    chk("drop_state", int'(state), 1);
    chk("drop_stage", int'(current_stage), 0);
    chk("drop_nf0", int'(nf[0]), 4);
    chk("drop_dft", int'(dftpts), 1200);
    fd0 = fd_count;
    run_after_sink(240, 0);
    tick();
    chk("f1_frame_done_once", fd_count - fd0, 1);
    chk("f1_ready", int'(sink_ready), 1);

    // unsupported size in idle sink
    send_sop(1000);
    chk("unsup_pulse", int'(err_unsup), 1);
    chk("unsup_state", int'(state), 0);
    chk("unsup_dft", int'(dftpts), 1200);
    chk("unsup_ready", int'(sink_ready), 1);

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 1) == 1) send_sop(int'($urandom_range(0, 1199)));
      send_sop(1200);
      sink_phase(int'($urandom_range(1, 20)));
      plen = int'($urandom_range(1, 30));
      fd0 = fd_count;
      run_after_sink(plen, 1);
      tick();
      chk("rand_frame_done_once", fd_count - fd0, 1);
    end

    // timeout in WR
    send_sop(1200);
    sink_phase(5);
    wait_state(1, 20);
    busy(1, 10);
    wait_state(2, 20);
    n = 0;
    while (int'(state) == 2 && n < 5000) begin
      tick();
      n++;
    end
    chk("timeout_len", n, TIMEOUT);
    chk("timeout_pulse", int'(err_timeout), 1);
    chk("timeout_state", int'(state), 0);
    chk("timeout_stage", int'(current_stage), 0);
    chk("timeout_ready", int'(sink_ready), 1);

    // reset mid-frame in WR, stage 2
    send_sop(1200);
    sink_phase(3);
    for (int s = 0; s < 3; s++) begin
      wait_state(1, 20);
      busy(1, 3);
      wait_state(2, 20);
      if (s < 2) busy(2, 3);
    end
    chk("pre_rst_stage", int'(current_stage), 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_state", int'(state), 0);
    chk("mrst_stage", int'(current_stage), 0);
    chk("mrst_dft", int'(dftpts), 0);
    chk("mrst_ready", int'(sink_ready), 1);
    chk("mrst_pulses", int'({frame_done, err_unsup, err_timeout, sop_dropped}), 0);
    for (int i = 0; i < 6; i++) chk("mrst_nf", int'(nf[i]), 1);

    // recovery frame
    send_sop(1200);
    sink_phase(4);
    fd0 = fd_count;
    run_after_sink(5, 1);
    tick();
    chk("recover_frame_done_once", fd_count - fd0, 1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
